// File: rtl/dispatch_queue.sv
// Multi-lane in-order dispatch queue: decodes fetch groups into a circular buffer
// and issues up to DISPATCH_WIDTH packets per cycle, gated by ROB/RS free counts.
package dispatch_pkg;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_MULT   = 3'd1,
    FU_LOAD   = 3'd2,
    FU_STORE  = 3'd3,
    FU_BRANCH = 3'd4
  } FUNC_TYPE;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } R_TYPE;

  typedef union packed {
    logic [31:0] raw;
    R_TYPE       r;
  } INST;

  typedef struct packed {
    logic        valid;
    INST         inst;
    logic [31:0] pc;
  } IF_ID_PACKET;

  typedef struct packed {
    logic        valid;
    INST         inst;
    logic [31:0] pc;
    FUNC_TYPE    function_type;
    logic        has_dest;
    logic [4:0]  dest_reg_idx;
    logic        halt;
    logic        illegal;
  } ID_IS_PACKET;
endpackage

module decoder
  import dispatch_pkg::*;
(
  input  INST      inst,
  output FUNC_TYPE function_type,
  output logic     has_dest,
  output logic     halt,
  output logic     illegal
);
  // Classify an instruction by its major opcode.
  always_comb begin
    function_type = FU_ALU;
    has_dest      = 1'b0;
    halt          = 1'b0;
    illegal       = 1'b0;
    case (inst.r.opcode)
      7'b0110011: begin
        has_dest      = 1'b1;
        function_type = (inst.r.funct7 == 7'b0000001) ? FU_MULT : FU_ALU;
      end
      7'b0010011, 7'b0110111, 7'b0010111: has_dest = 1'b1;
      7'b0000011: begin
        has_dest      = 1'b1;
        function_type = FU_LOAD;
      end
      7'b0100011: function_type = FU_STORE;
      7'b1100011: function_type = FU_BRANCH;
      7'b1101111, 7'b1100111: begin
        has_dest      = 1'b1;
        function_type = FU_BRANCH;
      end
      7'b1110011: halt = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end
endmodule

module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2,
  parameter int DEPTH          = 8,
  parameter int CNT_W          = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  IF_ID_PACKET              if_id_packet [FETCH_WIDTH],
  output logic                     in_ready,
  input  logic [CNT_W-1:0]         rob_free,
  input  logic [CNT_W-1:0]         alu_free,
  input  logic [CNT_W-1:0]         mult_free,
  input  logic [CNT_W-1:0]         load_free,
  input  logic [CNT_W-1:0]         store_free,
  input  logic [CNT_W-1:0]         branch_free,
  output ID_IS_PACKET              id_packet [DISPATCH_WIDTH],
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     halted
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_Q = PTR_W + 1;

  ID_IS_PACKET      queue_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_Q-1:0] count_r;
  logic             halted_r;

  FUNC_TYPE    dec_ft_s   [FETCH_WIDTH];
  logic        dec_dest_s [FETCH_WIDTH];
  logic        dec_halt_s [FETCH_WIDTH];
  logic        dec_ill_s  [FETCH_WIDTH];
  ID_IS_PACKET dec_s      [FETCH_WIDTH];

  logic             in_ready_s;
  logic [PTR_W-1:0] enq_off_s [FETCH_WIDTH];
  logic [CNT_Q-1:0] enq_cnt_s;
  logic [CNT_Q-1:0] enq_num_s;

  ID_IS_PACKET      win_s [DISPATCH_WIDTH];
  logic [CNT_W:0]   cls_cnt_s;
  logic [CNT_W-1:0] fr_s;
  logic             chain_s;
  logic             block_s;
  logic             ok_s;
  logic [CNT_Q-1:0] deq_num_s;
  logic             halt_disp_s;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_dec
    decoder u_decoder (
      .inst          (if_id_packet[g].inst),
      .function_type (dec_ft_s[g]),
      .has_dest      (dec_dest_s[g]),
      .halt          (dec_halt_s[g]),
      .illegal       (dec_ill_s[g])
    );
  end

  // Build decoded entries and their compacted write offsets.
  always_comb begin
    in_ready_s = ((CNT_Q'(DEPTH) - count_r) >= CNT_Q'(FETCH_WIDTH)) & ~halted_r & ~flush;
    enq_cnt_s  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      dec_s[i].valid         = if_id_packet[i].valid;
      dec_s[i].inst          = if_id_packet[i].inst;
      dec_s[i].pc            = if_id_packet[i].pc;
      dec_s[i].function_type = dec_ft_s[i];
      dec_s[i].has_dest      = dec_dest_s[i];
      dec_s[i].dest_reg_idx  = dec_dest_s[i] ? if_id_packet[i].inst.r.rd : ZERO_REG;
      dec_s[i].halt          = dec_halt_s[i];
      dec_s[i].illegal       = dec_ill_s[i];
      enq_off_s[i]           = enq_cnt_s[PTR_W-1:0];
      enq_cnt_s              = enq_cnt_s + CNT_Q'(if_id_packet[i].valid);
    end
    enq_num_s = in_ready_s ? enq_cnt_s : '0;
  end

  // In-order dispatch window; a class check counts same-class entries in lanes 0..j.
  always_comb begin
    chain_s     = 1'b1;
    block_s     = 1'b0;
    deq_num_s   = '0;
    halt_disp_s = 1'b0;
    cls_cnt_s   = '0;
    fr_s        = '0;
    ok_s        = 1'b0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      win_s[j] = queue_r[head_r + PTR_W'(j)];
    end
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      cls_cnt_s = '0;
      for (int k = 0; k <= j; k++) begin
        cls_cnt_s = cls_cnt_s + (CNT_W+1)'(~win_s[k].halt & ~win_s[k].illegal &
                                           (win_s[k].function_type == win_s[j].function_type));
      end
      case (win_s[j].function_type)
        FU_ALU:    fr_s = alu_free;
        FU_MULT:   fr_s = mult_free;
        FU_LOAD:   fr_s = load_free;
        FU_STORE:  fr_s = store_free;
        FU_BRANCH: fr_s = branch_free;
        default:   fr_s = '0;
      endcase
      ok_s = chain_s & (CNT_Q'(j) < count_r) & (CNT_W'(j) < rob_free) &
             (win_s[j].halt | win_s[j].illegal | (cls_cnt_s <= {1'b0, fr_s})) &
             ~halted_r & ~flush & ~block_s;
      id_packet[j]       = win_s[j];
      id_packet[j].valid = ok_s;
      halt_disp_s        = halt_disp_s | (ok_s & (win_s[j].halt | win_s[j].illegal));
      deq_num_s          = deq_num_s + CNT_Q'(ok_s);
      chain_s            = ok_s;
      block_s            = block_s | win_s[j].halt | win_s[j].illegal;
    end
  end

  // Queue storage, pointers, occupancy and sticky halt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      halted_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        queue_r[i] <= '0;
      end
    end else if (flush) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      halted_r <= 1'b0;
    end else begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (in_ready_s && if_id_packet[i].valid) begin
          queue_r[tail_r + enq_off_s[i]] <= dec_s[i];
        end
      end
      tail_r  <= tail_r + enq_num_s[PTR_W-1:0];
      head_r  <= head_r + deq_num_s[PTR_W-1:0];
      count_r <= count_r + enq_num_s - deq_num_s;
      if (halt_disp_s) begin
        halted_r <= 1'b1;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign queue_count = count_r;
  assign halted      = halted_r;
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue: reset, throughput, class gating,
// full/wrap ordering, halt and flush.
module tb_dispatch_queue;
  import dispatch_pkg::*;

  logic        clock;
  logic        reset;
  logic        flush;
  IF_ID_PACKET fetch [2];
  logic        in_ready;
  logic [3:0]  rob_free, alu_free, mult_free, load_free, store_free, branch_free;
  ID_IS_PACKET disp [2];
  logic [3:0]  queue_count;
  logic        halted;

  int checks = 0;
  int fails  = 0;

  dispatch_queue #(.FETCH_WIDTH(2), .DISPATCH_WIDTH(2), .DEPTH(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush), .if_id_packet(fetch), .in_ready(in_ready),
    .rob_free(rob_free), .alu_free(alu_free), .mult_free(mult_free), .load_free(load_free),
    .store_free(store_free), .branch_free(branch_free), .id_packet(disp),
    .queue_count(queue_count), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [31:0] HALT_I = 32'h10500073;

  function automatic logic [31:0] alu_i(input logic [4:0] rd);
    return {12'h001, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] mul_i(input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] ld_i(input logic [4:0] rd);
    return {12'h000, 5'd1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic drive(input logic v0, input logic [31:0] i0, input logic [31:0] p0,
                       input logic v1, input logic [31:0] i1, input logic [31:0] p1);
    fetch[0].valid = v0; fetch[0].inst = i0; fetch[0].pc = p0;
    fetch[1].valid = v1; fetch[1].inst = i1; fetch[1].pc = p1;
  endtask

  task automatic set_free(input logic [3:0] rob, input logic [3:0] alu, input logic [3:0] mul,
                          input logic [3:0] ld, input logic [3:0] st, input logic [3:0] br);
    rob_free = rob; alu_free = alu; mult_free = mul; load_free = ld; store_free = st; branch_free = br;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    set_free(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    #2;
    checks++; if (queue_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (disp[0].valid !== 1'b0 || disp[1].valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b%b expected 00", disp[1].valid, disp[0].valid); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
    step; step;
    reset = 1'b1;
    drive(1'b1, alu_i(5'd1), 32'h0, 1'b1, alu_i(5'd2), 32'h4); step;
    drive(1'b1, alu_i(5'd3), 32'h8, 1'b1, alu_i(5'd4), 32'hc); step;
    drive(1'b1, alu_i(5'd5), 32'h10, 1'b0, 32'h0, 32'h0); step;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    set_free(4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8);
    #1;
    checks++; if (queue_count !== 4'd5) begin fails++; $display("FAIL pre_reset_count: got %0d expected 5", queue_count); end
    checks++; if (disp[0].valid !== 1'b1 || disp[1].valid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %b%b expected 11", disp[1].valid, disp[0].valid); end
    reset = 1'b0;
    #1;
    checks++; if (queue_count !== 4'd0) begin fails++; $display("FAIL async_reset_count: got %0d expected 0", queue_count); end
    checks++; if (disp[0].valid !== 1'b0 || disp[1].valid !== 1'b0) begin fails++; $display("FAIL async_reset_valid: got %b%b expected 00", disp[1].valid, disp[0].valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL async_reset_in_ready: got %b expected 1", in_ready); end
    step;
    reset = 1'b1;
  endtask

  task automatic test_throughput;
    logic [31:0] base;
    base = 32'h200;
    set_free(4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8);
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(1'b1, alu_i(5'(2*c+1)), base + 32'(c*8), 1'b1, alu_i(5'(2*c+2)), base + 32'(c*8+4));
      else drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      #1;
      if (c == 0) begin
        checks++; if (disp[0].valid !== 1'b0) begin fails++; $display("FAIL thr_latency: got %b expected 0", disp[0].valid); end
        checks++; if (queue_count !== 4'd0) begin fails++; $display("FAIL thr_count0: got %0d expected 0", queue_count); end
      end else begin
        checks++; if (disp[0].valid !== 1'b1 || disp[0].pc !== base + 32'((c-1)*8)) begin fails++; $display("FAIL thr_lane0 c%0d: got v%b pc %h expected v1 pc %h", c, disp[0].valid, disp[0].pc, base + 32'((c-1)*8)); end
        checks++; if (disp[1].valid !== 1'b1 || disp[1].pc !== base + 32'((c-1)*8+4)) begin fails++; $display("FAIL thr_lane1 c%0d: got v%b pc %h expected v1 pc %h", c, disp[1].valid, disp[1].pc, base + 32'((c-1)*8+4)); end
        checks++; if (disp[0].dest_reg_idx !== 5'(2*(c-1)+1)) begin fails++; $display("FAIL thr_dest c%0d: got %0d expected %0d", c, disp[0].dest_reg_idx, 2*(c-1)+1); end
        checks++; if (queue_count !== 4'd2) begin fails++; $display("FAIL thr_count c%0d: got %0d expected 2", c, queue_count); end
      end
      step;
    end
    checks++; if (queue_count !== 4'd0) begin fails++; $display("FAIL thr_drain: got %0d expected 0", queue_count); end
  endtask

  task automatic test_class_blocking;
    set_free(4'd8, 4'd8, 4'd0, 4'd8, 4'd8, 4'd8);
    drive(1'b1, mul_i(5'd3), 32'h300, 1'b1, alu_i(5'd4), 32'h304); step;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (disp[0].valid !== 1'b0 || disp[1].valid !== 1'b0) begin fails++; $display("FAIL cls_block: got %b%b expected 00", disp[1].valid, disp[0].valid); end
    step;
    checks++; if (queue_count !== 4'd2) begin fails++; $display("FAIL cls_hold: got %0d expected 2", queue_count); end
    mult_free = 4'd1;
    #1;
    checks++; if (disp[0].valid !== 1'b1 || disp[0].pc !== 32'h300 || disp[0].function_type !== FU_MULT) begin fails++; $display("FAIL cls_lane0: got v%b pc %h expected v1 pc 300 mult", disp[0].valid, disp[0].pc); end
    checks++; if (disp[1].valid !== 1'b1 || disp[1].pc !== 32'h304) begin fails++; $display("FAIL cls_lane1: got v%b pc %h expected v1 pc 304", disp[1].valid, disp[1].pc); end
    step;
    checks++; if (queue_count !== 4'd0) begin fails++; $display("FAIL cls_drain: got %0d expected 0", queue_count); end
  endtask

  task automatic test_cumulative;
    set_free(4'd8, 4'd8, 4'd8, 4'd1, 4'd8, 4'd8);
    drive(1'b1, ld_i(5'd6), 32'h400, 1'b1, ld_i(5'd7), 32'h404); step;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (disp[0].valid !== 1'b1 || disp[0].pc !== 32'h400) begin fails++; $display("FAIL cum_lane0: got v%b pc %h expected v1 pc 400", disp[0].valid, disp[0].pc); end
    checks++; if (disp[1].valid !== 1'b0) begin fails++; $display("FAIL cum_lane1: got %b expected 0", disp[1].valid); end
    step;
    checks++; if (queue_count !== 4'd1) begin fails++; $display("FAIL cum_count: got %0d expected 1", queue_count); end
    load_free = 4'd0;
    drive(1'b1, alu_i(5'd8), 32'h408, 1'b1, alu_i(5'd9), 32'h40c);
    #1;
    checks++; if (disp[0].valid !== 1'b0) begin fails++; $display("FAIL cum_zero_free: got %b expected 0", disp[0].valid); end
    step;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    set_free(4'd1, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8);
    #1;
    checks++; if (queue_count !== 4'd3) begin fails++; $display("FAIL cum_count3: got %0d expected 3", queue_count); end
    checks++; if (disp[0].valid !== 1'b1 || disp[0].pc !== 32'h404 || disp[1].valid !== 1'b0) begin fails++; $display("FAIL cum_rob1: got v%b%b pc %h expected v01 pc 404", disp[1].valid, disp[0].valid, disp[0].pc); end
    step;
    rob_free = 4'd8;
    #1;
    checks++; if (queue_count !== 4'd2) begin fails++; $display("FAIL cum_count2: got %0d expected 2", queue_count); end
    checks++; if (disp[0].valid !== 1'b1 || disp[0].pc !== 32'h408 || disp[1].valid !== 1'b1 || disp[1].pc !== 32'h40c) begin fails++; $display("FAIL cum_alus: got v%b%b pc %h/%h expected v11 pc 408/40c", disp[1].valid, disp[0].valid, disp[0].pc, disp[1].pc); end
    step;
    checks++; if (queue_count !== 4'd0) begin fails++; $display("FAIL cum_drain: got %0d expected 0", queue_count); end
  endtask

  task automatic test_full_wrap;
    logic [31:0] sb [$];
    logic [31:0] next_pc;
    int          lanes, ndeq, seen7, seen8;
    logic        gate, exp_rdy, exp_v;
    next_pc = 32'h500; seen7 = 0; seen8 = 0;
    for (int c = 0; c < 30; c++) begin
      gate  = (c < 5) || (c >= 11 && c < 16);
      lanes = (c == 3 || c == 8) ? 1 : ((c < 22) ? 2 : 0);
      if (gate) set_free(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      else set_free(4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8);
      drive(lanes >= 1, alu_i(5'd10), next_pc, lanes >= 2, alu_i(5'd11), next_pc + 32'h4);
      #1;
      exp_rdy = (8 - sb.size()) >= 2;
      ndeq    = gate ? 0 : ((sb.size() < 2) ? sb.size() : 2);
      if (sb.size() == 7 && !exp_rdy) seen7++;
      if (sb.size() == 8) seen8++;
      checks++; if (queue_count !== 4'(sb.size())) begin fails++; $display("FAIL wrap_count c%0d: got %0d expected %0d", c, queue_count, sb.size()); end
      checks++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL wrap_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy); end
      for (int j = 0; j < 2; j++) begin
        exp_v = (j < ndeq);
        checks++; if (disp[j].valid !== exp_v) begin fails++; $display("FAIL wrap_valid c%0d l%0d: got %b expected %b", c, j, disp[j].valid, exp_v); end
        if (exp_v) begin
          checks++; if (disp[j].pc !== sb[j]) begin fails++; $display("FAIL wrap_pc c%0d l%0d: got %h expected %h", c, j, disp[j].pc, sb[j]); end
        end
      end
      step;
      for (int j = 0; j < ndeq; j++) void'(sb.pop_front());
      if (exp_rdy) begin
        for (int j = 0; j < lanes; j++) sb.push_back(next_pc + 32'(4*j));
        next_pc = next_pc + 32'(4*lanes);
      end
    end
    checks++; if (seen7 == 0 || seen8 == 0) begin fails++; $display("FAIL wrap_fill: got seen7=%0d seen8=%0d expected both nonzero", seen7, seen8); end
    checks++; if (queue_count !== 4'd0) begin fails++; $display("FAIL wrap_drain: got %0d expected 0", queue_count); end
  endtask

  task automatic test_halt_flush;
    set_free(4'd0, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8);
    drive(1'b1, alu_i(5'd12), 32'h600, 1'b1, HALT_I, 32'h604); step;
    drive(1'b1, alu_i(5'd13), 32'h608, 1'b0, 32'h0, 32'h0); step;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    rob_free = 4'd8;
    #1;
    checks++; if (queue_count !== 4'd3) begin fails++; $display("FAIL hlt_count3: got %0d expected 3", queue_count); end
    checks++; if (disp[0].valid !== 1'b1 || disp[0].pc !== 32'h600) begin fails++; $display("FAIL hlt_lane0: got v%b pc %h expected v1 pc 600", disp[0].valid, disp[0].pc); end
    checks++; if (disp[1].valid !== 1'b1 || disp[1].halt !== 1'b1 || disp[1].pc !== 32'h604) begin fails++; $display("FAIL hlt_lane1: got v%b h%b pc %h expected v1 h1 pc 604", disp[1].valid, disp[1].halt, disp[1].pc); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL hlt_not_yet: got %b expected 0", halted); end
    step;
    for (int c = 0; c < 2; c++) begin
      checks++; if (halted !== 1'b1) begin fails++; $display("FAIL hlt_sticky c%0d: got %b expected 1", c, halted); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hlt_in_ready c%0d: got %b expected 0", c, in_ready); end
      checks++; if (disp[0].valid !== 1'b0) begin fails++; $display("FAIL hlt_trailing c%0d: got %b expected 0", c, disp[0].valid); end
      checks++; if (queue_count !== 4'd1) begin fails++; $display("FAIL hlt_count1 c%0d: got %0d expected 1", c, queue_count); end
      step;
    end
    flush = 1'b1;
    #1;
    checks++; if (disp[0].valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL flush_cycle: got v%b rdy%b expected v0 rdy0", disp[0].valid, in_ready); end
    step;
    flush = 1'b0;
    #1;
    checks++; if (queue_count !== 4'd0) begin fails++; $display("FAIL flush_count: got %0d expected 0", queue_count); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL flush_halted: got %b expected 0", halted); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset;
    test_throughput;
    test_class_blocking;
    test_cumulative;
    test_full_wrap;
    test_halt_flush;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
